// File: rtl/spi_buffered.sv
// SPI slave clocked directly by SCK, with an RX FIFO of received words and a TX FIFO of
// words to send. Words are WORD_BITS long, MSB- or LSB-first, and framed by the chip select.
module spi_buffered #(
    parameter int WORD_BITS = 8,
    parameter int RX_DEPTH  = 4,
    parameter int TX_DEPTH  = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cs,
    input  logic                         mosi,
    output logic                         miso,
    output logic [WORD_BITS-1:0]         rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    input  logic [WORD_BITS-1:0]         tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [$clog2(RX_DEPTH+1)-1:0] rx_count,
    output logic [$clog2(TX_DEPTH+1)-1:0] tx_count,
    output logic                         rx_overflow,
    output logic                         tx_underrun,
    output logic                         busy
);
    localparam int CW  = $clog2(WORD_BITS);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXC = $clog2(RX_DEPTH + 1);
    localparam int TXC = $clog2(TX_DEPTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WORD_BITS - 1);
    localparam logic [RXC-1:0] RX_FULL  = RXC'(RX_DEPTH);
    localparam logic [TXC-1:0] TX_FULL  = TXC'(TX_DEPTH);

    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-2:0] rx_shift_q, rx_shift_d;
    logic [WORD_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [WORD_BITS-1:0] rx_mem [RX_DEPTH];
    logic [WORD_BITS-1:0] tx_mem [TX_DEPTH];
    logic [RXA-1:0]       rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [TXA-1:0]       tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [RXC-1:0]       rx_cnt_q, rx_cnt_d;
    logic [TXC-1:0]       tx_cnt_q, tx_cnt_d;
    logic                 rx_ovf_q, rx_ovf_d, tx_udr_q, tx_udr_d;
    logic                 word_start, word_done;
    logic                 rx_push, rx_pop, tx_push, tx_pop, tx_empty;
    logic [WORD_BITS-1:0] rx_word, tx_head, tx_load;

    // NOTE: every signal assigned in an always_comb gets a value on every path, so no latches.
    always_comb begin
        word_start = !cs && (bit_cnt_q == '0);
        word_done  = !cs && (bit_cnt_q == LAST_BIT);
        bit_cnt_d  = (cs || word_done) ? '0 : bit_cnt_q + CW'(1);

        if (LSB_FIRST != 0) begin
            rx_word    = {mosi, rx_shift_q};
            rx_shift_d = rx_word[WORD_BITS-1:1];
        end else begin
            rx_word    = {rx_shift_q, mosi};
            rx_shift_d = rx_word[WORD_BITS-2:0];
        end
        if (cs) rx_shift_d = '0;
    end

    // A pop on the same edge frees the slot, so a word completing into a full FIFO still lands.
    always_comb begin
        rx_pop   = (rx_cnt_q != '0) && rx_ready;
        rx_push  = word_done && ((rx_cnt_q != RX_FULL) || rx_pop);
        rx_ovf_d = word_done && (rx_cnt_q == RX_FULL) && !rx_pop;
        rx_wr_d  = rx_wr_q + RXA'(rx_push);
        rx_rd_d  = rx_rd_q + RXA'(rx_pop);
        rx_cnt_d = rx_cnt_q + RXC'(rx_push) - RXC'(rx_pop);

        tx_empty = (tx_cnt_q == '0);
        tx_head  = tx_mem[tx_rd_q];
        tx_push  = tx_valid && (tx_cnt_q != TX_FULL);
        tx_pop   = word_start && !tx_empty;
        tx_udr_d = word_start && tx_empty;
        tx_wr_d  = tx_wr_q + TXA'(tx_push);
        tx_rd_d  = tx_rd_q + TXA'(tx_pop);
        tx_cnt_d = tx_cnt_q + TXC'(tx_push) - TXC'(tx_pop);
    end

    // The first bit of a word comes straight from the FIFO head; the rest from tx_shift.
    always_comb begin
        tx_load = tx_empty ? '0 : tx_head;
        if (cs) begin
            tx_shift_d = '0;
            miso       = 1'b0;
        end else if (word_start) begin
            tx_shift_d = (LSB_FIRST != 0) ? (tx_load >> 1) : (tx_load << 1);
            miso       = (LSB_FIRST != 0) ? tx_load[0] : tx_load[WORD_BITS-1];
        end else begin
            tx_shift_d = (LSB_FIRST != 0) ? (tx_shift_q >> 1) : (tx_shift_q << 1);
            miso       = (LSB_FIRST != 0) ? tx_shift_q[0] : tx_shift_q[WORD_BITS-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_cnt_q   <= '0;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_cnt_q   <= '0;
            rx_ovf_q   <= 1'b0;
            tx_udr_q   <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_ovf_q   <= rx_ovf_d;
            tx_udr_q   <= tx_udr_d;
        end
    end

    // NOTE: storage is not reset; pointers and counts alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (!reset && rx_push) rx_mem[rx_wr_q] <= rx_word;
        if (!reset && tx_push) tx_mem[tx_wr_q] <= tx_data;
    end

    assign rx_data     = rx_mem[rx_rd_q];
    assign rx_valid    = (rx_cnt_q != '0);
    assign tx_ready    = (tx_cnt_q != TX_FULL);
    assign rx_count    = rx_cnt_q;
    assign tx_count    = tx_cnt_q;
    assign rx_overflow = rx_ovf_q;
    assign tx_underrun = tx_udr_q;
    assign busy        = !cs && (bit_cnt_q != '0);
endmodule

// File: tb/tb_spi_buffered.sv
// Directed bench for spi_buffered: one MSB-first and one LSB-first instance share all inputs.
module tb_spi_buffered;
    logic       clk = 1'b0;
    logic       reset, cs, mosi, rx_ready, tx_valid;
    logic [7:0] tx_data;

    logic       miso0, rx_valid0, tx_ready0, rx_overflow0, tx_underrun0, busy0;
    logic [7:0] rx_data0;
    logic [2:0] rx_count0, tx_count0;
    logic       miso1, rx_valid1, tx_ready1, rx_overflow1, tx_underrun1, busy1;
    logic [7:0] rx_data1;
    logic [2:0] rx_count1, tx_count1;

    int n_tests = 0;
    int n_fail  = 0;
    int udr, ovf, ovf_total;

    always #5 clk = ~clk;

    spi_buffered #(.WORD_BITS(8), .RX_DEPTH(4), .TX_DEPTH(4), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .reset(reset), .cs(cs), .mosi(mosi), .miso(miso0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready0),
        .rx_count(rx_count0), .tx_count(tx_count0),
        .rx_overflow(rx_overflow0), .tx_underrun(tx_underrun0), .busy(busy0)
    );

    spi_buffered #(.WORD_BITS(8), .RX_DEPTH(4), .TX_DEPTH(4), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .reset(reset), .cs(cs), .mosi(mosi), .miso(miso1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready1),
        .rx_count(rx_count1), .tx_count(tx_count1),
        .rx_overflow(rx_overflow1), .tx_underrun(tx_underrun1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d);
        cs       = 1'b1;
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        cs       = 1'b1;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    // Shift one word with cs low; w and exp_miso are listed in transmission order, first bit in [7].
    task automatic send_word(input logic [7:0] w, input logic [7:0] exp_miso, input bit use_lsb,
                             output int udr_n, output int ovf_n);
        udr_n = 0;
        ovf_n = 0;
        for (int i = 7; i >= 0; i--) begin
            cs   = 1'b0;
            mosi = w[i];
            #1;
            check($sformatf("miso %s bit%0d", use_lsb ? "lsb" : "msb", 7 - i),
                  use_lsb ? miso1 : miso0, exp_miso[i]);
            tick();
            udr_n += (use_lsb ? tx_underrun1 : tx_underrun0) ? 1 : 0;
            ovf_n += (use_lsb ? rx_overflow1 : rx_overflow0) ? 1 : 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cs = 1'b1; mosi = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0;
        do_reset();
        check("reset rx_valid", rx_valid0, 0);
        check("reset tx_ready", tx_ready0, 1);
        check("reset rx_count", rx_count0, 0);
        check("reset tx_count", tx_count0, 0);
        check("reset busy", busy0, 0);
        check("reset flags", {rx_overflow0, tx_underrun0}, 0);
        check("reset miso", miso0, 0);

        // Receive 0xB3 with an empty TX FIFO: miso stays 0 and one underrun pulse.
        send_word(8'hB3, 8'h00, 1'b0, udr, ovf);
        check("rx B3 valid", rx_valid0, 1);
        check("rx B3 data", rx_data0, 8'hB3);
        check("rx B3 count", rx_count0, 1);
        check("empty tx underrun pulses", udr, 1);
        check("rx B3 no overflow", ovf, 0);
        check("lsb dut B3 reorder", rx_data1, 8'hCD);
        pop_rx();
        check("rx pop count", rx_count0, 0);

        // Two TX words streamed back to back.
        push_tx(8'h55);
        push_tx(8'h80);
        check("tx count 2", tx_count0, 2);
        send_word(8'h00, 8'h55, 1'b0, udr, ovf);
        check("tx 55 no underrun", udr, 0);
        send_word(8'h00, 8'h80, 1'b0, udr, ovf);
        check("tx 80 no underrun", udr, 0);
        check("tx drained count", tx_count0, 0);

        // Overflow: five words, no pops.
        do_reset();
        ovf_total = 0;
        for (int k = 1; k <= 5; k++) begin
            send_word(8'(k * 8'h11), 8'h00, 1'b0, udr, ovf);
            ovf_total += ovf;
            if (k == 4) check("no overflow by word4", ovf_total, 0);
        end
        check("overflow pulses", ovf_total, 1);
        check("overflow on word5", ovf, 1);
        check("full rx_count", rx_count0, 4);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("retained word%0d", k), rx_data0, 8'(k * 8'h11));
            pop_rx();
        end
        check("rx empty after pops", rx_valid0, 0);

        // Partial word aborted by cs, then a clean 0xFF word.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cs = 1'b0; mosi = 1'b1;
            tick();
        end
        check("busy mid-word", busy0, 1);
        cs = 1'b1;
        tick();
        check("busy after abort", busy0, 0);
        check("no stray push", rx_count0, 0);
        send_word(8'hFF, 8'h00, 1'b0, udr, ovf);
        check("ff count", rx_count0, 1);
        check("ff data", rx_data0, 8'hFF);

        // LSB-first instance: TX 0x01 and RX 0x01 (first transmitted bit is 1).
        do_reset();
        push_tx(8'h01);
        send_word(8'h80, 8'h80, 1'b1, udr, ovf);
        check("lsb rx data", rx_data1, 8'h01);
        check("lsb rx count", rx_count1, 1);
        check("lsb no underrun", udr, 0);

        // Reset mid-word with a TX word queued and cs held low.
        push_tx(8'hAA);
        for (int i = 0; i < 3; i++) begin
            cs = 1'b0; mosi = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        check("midreset rx_valid", rx_valid1, 0);
        check("midreset tx_ready", tx_ready1, 1);
        check("midreset counts", {rx_count1, tx_count1}, 0);
        check("midreset busy", busy1, 0);
        check("midreset flags", {rx_overflow1, tx_underrun1}, 0);
        check("midreset miso", miso1, 0);
        reset = 1'b0;
        cs    = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
